// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO write-side bundle for fifo_wr_arbiter.
// The master modport is the arbiter; the slave modport is the producers/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned M    = 4
);
    localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]   req;
    logic [NREQ*M-1:0] req_data;
    logic              fifo_full;
    logic [NREQ-1:0]   gnt;
    logic              fifo_we;
    logic [M-1:0]      fifo_wd;
    logic              busy;
    logic [OW-1:0]     owner;

    modport master (
        input  req, req_data, fifo_full,
        output gnt, fifo_we, fifo_wd, busy, owner
    );

    modport slave (
        output req, req_data, fifo_full,
        input  gnt, fifo_we, fifo_wd, busy, owner
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// A grant lasts up to BURST words; each exit through IDLE costs one arbitration cycle.
module fifo_wr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned M     = 4,
    parameter int unsigned BURST = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    fifo_wr_arbiter_if.master  arb_io
);
    localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned BW = $clog2(BURST + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_q,  last_d;
    logic [BW-1:0]   beat_q,  beat_d;

    logic [NREQ-1:0] gnt_c;
    logic [OW-1:0]   pick_c;
    logic            found_c;
    logic [OW-1:0]   cand_c;
    int unsigned     idx_c;
    logic [M-1:0]    slice_c [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign slice_c[i] = arb_io.req_data[i*M +: M];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= OW'(NREQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;
        gnt_c   = '0;
        pick_c  = '0;
        found_c = 1'b0;
        cand_c  = '0;
        idx_c   = 0;

        // First requester after the previous owner, wrapping modulo NREQ
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx_c  = (32'(last_q) + k) % NREQ;
            cand_c = OW'(idx_c);
            if (!found_c && arb_io.req[cand_c]) begin
                found_c = 1'b1;
                pick_c  = cand_c;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (found_c && !arb_io.fifo_full) begin
                    state_d = ST_BURST;
                    owner_d = pick_c;
                    last_d  = pick_c;
                    beat_d  = '0;
                end
            end
            ST_BURST: begin
                if (arb_io.req[owner_q] && !arb_io.fifo_full) begin
                    gnt_c[owner_q] = 1'b1;
                end
                if (|gnt_c) begin
                    beat_d = beat_q + BW'(1);
                end
                if (!arb_io.req[owner_q] || ((|gnt_c) && (beat_q == BW'(BURST - 1)))) begin
                    state_d = ST_IDLE;
                    beat_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A word granted during reset must not reach the FIFO
        if (!reset_n) begin
            gnt_c = '0;
        end
    end

    assign arb_io.gnt     = gnt_c;
    assign arb_io.fifo_we = |gnt_c;
    assign arb_io.fifo_wd = slice_c[owner_q];
    assign arb_io.busy    = (state_q == ST_BURST);
    assign arb_io.owner   = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random checks of fifo_wr_arbiter against a cycle model,
// a write-order scoreboard and a small FIFO occupancy model.
module tb_fifo_wr_arbiter;
    localparam int unsigned NREQ     = 4;
    localparam int unsigned M        = 8;
    localparam int unsigned BURST    = 4;
    localparam int unsigned OW       = 2;
    localparam int unsigned FIFO_CAP = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .M(M)) bus ();

    fifo_wr_arbiter #(.NREQ(NREQ), .M(M), .BURST(BURST)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .arb_io  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus state
    logic [NREQ-1:0]   req_r = '0;
    logic [NREQ*M-1:0] data_r = '0;
    logic              force_full = 1'b0;
    logic              use_model = 1'b0;
    logic              pop = 1'b0;
    bit                inc = 1'b1;
    bit                soak = 1'b0;
    bit                sb_en = 1'b1;
    int                left [NREQ];
    int                sent [NREQ];
    logic [M-1:0]      base [NREQ];
    logic [M-1:0]      exp_q [$];

    // FIFO occupancy model
    int                fifo_cnt = 0;
    logic [M-1:0]      wr_log [$];
    logic              f_we = 1'b0;
    logic              f_pop = 1'b0;
    logic [M-1:0]      f_wd = '0;

    assign bus.req       = req_r;
    assign bus.req_data  = data_r;
    assign bus.fifo_full = use_model ? (fifo_cnt >= FIFO_CAP) : force_full;

    // Snapshot of the cycle just finished
    logic [NREQ-1:0] s_gnt;
    logic            s_we, s_busy, s_full;
    logic [OW-1:0]   s_owner;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_r[i] = (left[i] > 0);
            data_r[i*M +: M] = base[i] + (inc ? M'(sent[i]) : M'(0));
        end
    endtask

    task automatic soak_step();
        for (int i = 0; i < NREQ; i++) begin
            if (req_r[i] && s_gnt[i]) begin
                req_r[i] = ($urandom_range(0, 9) < 7);
                data_r[i*M +: M] = M'($urandom);
            end else if (req_r[i]) begin
                if ($urandom_range(0, 19) == 0) req_r[i] = 1'b0;
            end else if ($urandom_range(0, 9) < 3) begin
                req_r[i] = 1'b1;
                data_r[i*M +: M] = M'($urandom);
            end
        end
        force_full = ($urandom_range(0, 3) == 0);
    endtask

    task automatic tick();
        @(negedge clk);
        s_gnt   = bus.gnt;
        s_we    = bus.fifo_we;
        s_busy  = bus.busy;
        s_full  = bus.fifo_full;
        s_owner = bus.owner;
        @(posedge clk);
        #1;
        if (soak) begin
            soak_step();
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (s_gnt[i] && left[i] > 0) begin
                    left[i]--;
                    sent[i]++;
                end
            end
            drive();
        end
    endtask

    task automatic reset_dut();
        for (int i = 0; i < NREQ; i++) begin
            left[i] = 0;
            sent[i] = 0;
            base[i] = '0;
        end
        drive();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // FIFO model: capture at negedge, commit at the write edge
    always @(negedge clk) begin
        f_we  = bus.fifo_we;
        f_wd  = bus.fifo_wd;
        f_pop = pop;
    end

    always @(posedge clk) begin
        if (!use_model) begin
            fifo_cnt <= 0;
            wr_log.delete();
        end else begin
            if (f_we) wr_log.push_back(f_wd);
            fifo_cnt <= fifo_cnt + (f_we ? 1 : 0) - (f_pop ? 1 : 0);
        end
    end

    // Write-order scoreboard
    always @(negedge clk) begin
        if (sb_en && bus.fifo_we === 1'b1) begin
            n_tests++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_extra observed=%0h expected=none", bus.fifo_wd);
            end
            if (exp_q.size() > 0) chk("sb_word", bus.fifo_wd, exp_q.pop_front());
        end
    end

    // Cycle model of the arbiter; state advanced here stands for the next rising edge
    bit              m_burst = 1'b0;
    bit              m_valid = 1'b0;
    bit              m_hit;
    logic [OW-1:0]   m_owner, m_last, m_cand;
    int              m_beat;
    logic [NREQ-1:0] m_gnt;

    always @(negedge clk) begin
        chk("onehot0", 64'($onehot0(bus.gnt)), 1);
        if (!reset_n) begin
            chk("rst_gnt", bus.gnt, 0);
            chk("rst_we", bus.fifo_we, 0);
            m_burst = 1'b0;
            m_owner = '0;
            m_last  = OW'(NREQ - 1);
            m_beat  = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            chk("m_busy", bus.busy, m_burst);
            if (!m_burst) begin
                chk("m_idle_gnt", bus.gnt, 0);
                chk("m_idle_we", bus.fifo_we, 0);
                m_hit  = 1'b0;
                m_cand = m_last;
                for (int k = 0; k < NREQ && !m_hit; k++) begin
                    m_cand = (m_cand == OW'(NREQ - 1)) ? '0 : m_cand + 1'b1;
                    if (bus.req[m_cand]) m_hit = 1'b1;
                end
                if (m_hit && !bus.fifo_full) begin
                    m_burst = 1'b1;
                    m_owner = m_cand;
                    m_last  = m_cand;
                    m_beat  = 0;
                end
            end else begin
                chk("m_owner", bus.owner, m_owner);
                m_gnt = '0;
                m_gnt[m_owner] = bus.req[m_owner] & ~bus.fifo_full;
                chk("m_gnt", bus.gnt, m_gnt);
                chk("m_we", bus.fifo_we, |m_gnt);
                if (|m_gnt) begin
                    chk("m_wd", bus.fifo_wd, bus.req_data[32'(m_owner)*M +: M]);
                    m_beat++;
                end
                if (!bus.req[m_owner] || ((|m_gnt) && m_beat == BURST)) begin
                    m_burst = 1'b0;
                    m_beat  = 0;
                end
            end
        end
    end

    logic [0:9] t1_pat;

    initial begin
        // Reset with every producer requesting: nothing may be granted
        for (int i = 0; i < NREQ; i++) begin
            left[i] = 1;
            sent[i] = 0;
            base[i] = M'(i);
        end
        drive();
        tick();
        tick();
        chk("reset_gnt", s_gnt, 0);
        chk("reset_we", s_we, 0);
        chk("reset_busy", s_busy, 0);
        chk("reset_owner", s_owner, 0);
        reset_dut();

        // Single requester: 8 words in two bursts with one idle cycle between
        inc = 1'b1;
        base[0] = 8'h01;
        left[0] = 8;
        for (int i = 0; i < 8; i++) exp_q.push_back(M'(i + 1));
        drive();
        t1_pat = 10'b0111101111;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c <= 10) chk("t1_gnt", s_gnt, t1_pat[c-1] ? 4'b0001 : 4'b0000);
            if (c == 6) chk("t1_idle_busy", s_busy, 0);
        end
        chk("t1_sb_left", 64'(exp_q.size()), 0);

        // Round-robin with all producers requesting: bursts 0,1,2,3,0
        reset_dut();
        inc = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            base[i] = M'(i);
            left[i] = 1000;
        end
        for (int b = 0; b < 5; b++)
            for (int w = 0; w < 4; w++) exp_q.push_back(M'(b % 4));
        drive();
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (c % 5 == 2) begin
                chk("t2_owner", s_owner, (c / 5) % 4);
                chk("t2_busy", s_busy, 1);
            end
            if (c % 5 == 1) chk("t2_arb_gnt", s_gnt, 0);
        end
        for (int i = 0; i < NREQ; i++) left[i] = 0;
        drive();
        tick();
        tick();
        chk("t2_sb_left", 64'(exp_q.size()), 0);

        // Early release by producer 2 hands over to producer 3
        reset_dut();
        inc = 1'b1;
        base[2] = 8'h21;
        left[2] = 2;
        base[3] = 8'h31;
        left[3] = 4;
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h22);
        for (int i = 0; i < 4; i++) exp_q.push_back(M'(8'h31 + i));
        drive();
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 2) chk("t3_first_gnt", s_gnt, 4'b0100);
            if (c == 4) chk("t3_release_gnt", s_gnt, 0);
            if (c == 5) chk("t3_idle_busy", s_busy, 0);
            if (c == 6) begin
                chk("t3_next_gnt", s_gnt, 4'b1000);
                chk("t3_next_owner", s_owner, 3);
            end
        end
        chk("t3_sb_left", 64'(exp_q.size()), 0);

        // Full stall against a 4-word FIFO with the read side idle
        reset_dut();
        use_model = 1'b1;
        base[0] = 8'h41;
        left[0] = 6;
        for (int i = 0; i < 6; i++) exp_q.push_back(M'(8'h41 + i));
        drive();
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c >= 2 && c <= 5) chk("t4_fill_we", s_we, 1);
            if (c >= 6) begin
                chk("t4_full_we", s_we, 0);
                chk("t4_full_flag", s_full, 1);
            end
        end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        tick();
        chk("t4_pop_full", s_full, 0);
        tick();
        chk("t4_refill_gnt", s_gnt, 4'b0001);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t4_stall_we", s_we, 0);
            chk("t4_stall_busy", s_busy, 1);
        end
        chk("t4_log_5", 64'(wr_log.size()), 5);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        tick();
        chk("t4_last_we", s_we, 1);
        tick();
        tick();
        chk("t4_log_6", 64'(wr_log.size()), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < wr_log.size()) chk("t4_log_word", wr_log[i], M'(8'h41 + i));
        end
        chk("t4_sb_left", 64'(exp_q.size()), 0);
        use_model = 1'b0;

        // Reset in beat 2 of producer 1's burst, then producer 0 goes first
        reset_dut();
        base[1] = 8'h11;
        left[1] = 3;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h12);
        drive();
        tick();
        tick();
        chk("t5_gnt1", s_gnt, 4'b0010);
        tick();
        reset_n = 1'b0;
        tick();
        chk("t5_rst_gnt", s_gnt, 0);
        chk("t5_rst_we", s_we, 0);
        reset_n = 1'b1;
        base[0] = 8'h01;
        left[0] = 2;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h13);
        drive();
        tick();
        chk("t5_post_busy", s_busy, 0);
        tick();
        chk("t5_post_gnt", s_gnt, 4'b0001);
        for (int c = 0; c < 8; c++) tick();
        chk("t5_sb_left", 64'(exp_q.size()), 0);

        // Random requests and full flag, checked by the cycle model
        reset_dut();
        sb_en = 1'b0;
        soak  = 1'b1;
        req_r = '0;
        for (int c = 0; c < 10000; c++) tick();
        soak = 1'b0;
        force_full = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
